// File: rtl/uart_apb_ctrl_if.sv
// APB link between the UART controller (master) and the UART register block (slave).
interface uart_apb_ctrl_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [1:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA
  );
endinterface

// File: rtl/uart_apb_ctrl.sv
// UART front end: runs the DLAB-latch configuration sequence on the UART sideband,
// then arbitrates the single APB data port between a TX byte source and an RX drain.
module uart_apb_ctrl #(
  parameter logic [15:0] DIV_CFG   = 16'd13,
  parameter logic [7:0]  LCR_CFG   = 8'h7B,
  parameter logic [7:0]  FCR_CFG   = 8'h01,
  parameter logic [7:0]  IER_CFG   = 8'hFF,
  parameter logic [7:0]  MCR_CFG   = 8'h10,
  parameter int unsigned LATCH_CYC = 5,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        init_req,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  input  logic        rx_en,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        cfg_done,
  uart_apb_ctrl_if.master apb,
  input  logic [7:0]  LSR,
  output logic [15:0] DLR,
  output logic [7:0]  LCR,
  output logic [7:0]  FCR,
  output logic [7:0]  IER,
  output logic [7:0]  MCR
);

  typedef enum logic [2:0] {
    ST_DLAB,
    ST_CFG,
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  typedef enum logic {
    GR_TX,
    GR_RX
  } grant_t;

  localparam logic [7:0] LCR_DLAB   = 8'h80;
  localparam logic [7:0] LATCH_LAST = 8'(LATCH_CYC - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYC);

  state_t     state;
  grant_t     last_grant;
  logic [7:0] latch_cnt;
  logic [3:0] gap_cnt;
  logic       init_pend;

  logic thre;
  logic dr;
  logic tx_cand;
  logic rx_cand;
  logic arb_open;
  logic tx_grant;
  logic rx_grant;
  logic unused_lsr;

  // Arbitration is purely a function of registered state and LSR/requests so
  // tx_ready can be offered without looking at tx_valid.
  always_comb begin
    thre       = LSR[5];
    dr         = LSR[0];
    unused_lsr = ^{LSR[7:6], LSR[4:1]};
    tx_cand    = tx_valid & thre;
    rx_cand    = rx_en & dr;
    arb_open   = (state == ST_IDLE) && (gap_cnt == 4'd0) && !init_pend;
    tx_ready   = arb_open & thre & ~(rx_cand & (last_grant == GR_TX));
    tx_grant   = tx_valid & tx_ready;
    rx_grant   = arb_open & rx_cand & ~tx_grant;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= ST_DLAB;
      last_grant  <= GR_RX;
      latch_cnt   <= '0;
      gap_cnt     <= '0;
      init_pend   <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      cfg_done    <= 1'b0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      DLR         <= '0;
      LCR         <= LCR_DLAB;
      FCR         <= '0;
      IER         <= '0;
      MCR         <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (init_req) init_pend <= 1'b1;

      case (state)
        ST_DLAB: begin
          DLR <= DIV_CFG;
          LCR <= LCR_DLAB;
          if (latch_cnt == LATCH_LAST) begin
            latch_cnt <= '0;
            LCR       <= LCR_CFG;
            FCR       <= FCR_CFG;
            IER       <= IER_CFG;
            MCR       <= MCR_CFG;
            state     <= ST_CFG;
          end else begin
            latch_cnt <= latch_cnt + 8'd1;
          end
        end

        ST_CFG: begin
          cfg_done <= 1'b1;
          state    <= ST_IDLE;
        end

        ST_IDLE: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (init_pend) begin
            // A request arriving in this very cycle stays pending for the next round.
            init_pend <= init_req;
            cfg_done  <= 1'b0;
            latch_cnt <= '0;
            DLR       <= DIV_CFG;
            LCR       <= LCR_DLAB;
            state     <= ST_DLAB;
          end else if (tx_grant) begin
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b1;
            apb.PADDR   <= 2'b00;
            apb.PWDATA  <= tx_data;
            last_grant  <= GR_TX;
            state       <= ST_SETUP;
          end else if (rx_grant) begin
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= 2'b00;
            last_grant  <= GR_RX;
            state       <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (!apb.PWRITE) begin
            rx_data  <= apb.PRDATA;
            rx_valid <= 1'b1;
          end
          apb.PSEL    <= 1'b0;
          apb.PENABLE <= 1'b0;
          gap_cnt     <= GAP_LOAD;
          state       <= ST_IDLE;
        end

        default: begin
          apb.PSEL    <= 1'b0;
          apb.PENABLE <= 1'b0;
          state       <= ST_DLAB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Directed bench for uart_apb_ctrl: stimulus pushes expected APB transfers and RX bytes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_apb_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        init_req;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_en;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cfg_done;
  logic [7:0]  LSR;
  logic [15:0] DLR;
  logic [7:0]  LCR;
  logic [7:0]  FCR;
  logic [7:0]  IER;
  logic [7:0]  MCR;

  uart_apb_ctrl_if apb ();

  uart_apb_ctrl #(
    .DIV_CFG   (16'd13),
    .LCR_CFG   (8'h7B),
    .FCR_CFG   (8'h01),
    .IER_CFG   (8'hFF),
    .MCR_CFG   (8'h10),
    .LATCH_CYC (5),
    .GAP_CYC   (2)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .init_req (init_req),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_en    (rx_en),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .cfg_done (cfg_done),
    .apb      (apb.master),
    .LSR      (LSR),
    .DLR      (DLR),
    .LCR      (LCR),
    .FCR      (FCR),
    .IER      (IER),
    .MCR      (MCR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       wr;
    logic [7:0] data;
  } apb_exp_t;

  apb_exp_t   apb_q[$];
  logic [7:0] rx_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever a transfer completes or a byte is delivered.
  initial begin
    logic     prev_psel;
    apb_exp_t e;
    logic [7:0] rexp;
    prev_psel = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESET) begin
        if (apb.PSEL && !apb.PENABLE) check("apb_not_adjacent", {31'd0, prev_psel}, 32'd0);
        if (apb.PSEL && apb.PENABLE) begin
          if (apb_q.size() == 0) begin
            check("apb_unexpected_xfer", 32'd1, 32'd0);
          end else begin
            e = apb_q.pop_front();
            check("apb_dir", {31'd0, apb.PWRITE}, {31'd0, e.wr});
            check("apb_paddr", {30'd0, apb.PADDR}, 32'd0);
            if (e.wr) check("apb_wdata", {24'd0, apb.PWDATA}, {24'd0, e.data});
          end
        end
        if (rx_valid) begin
          if (rx_q.size() == 0) begin
            check("rx_unexpected", 32'd1, 32'd0);
          end else begin
            rexp = rx_q.pop_front();
            check("rx_data", {24'd0, rx_data}, {24'd0, rexp});
          end
        end
      end
      prev_psel = apb.PSEL;
    end
  end

  initial begin
    int  txn;
    int  rxn;
    int  waitn;
    logic acc;

    PRESET = 1'b0;
    init_req = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    rx_en = 1'b0;
    LSR = 8'h00;
    apb.PRDATA = 8'h00;
    #2 PRESET = 1'b1;

    // Reset state
    @(negedge PCLK);
    check("rst_lcr", {24'd0, LCR}, 32'h80);
    check("rst_dlr", {16'd0, DLR}, 32'd0);
    check("rst_outs", {28'd0, cfg_done, apb.PSEL, apb.PENABLE, tx_ready}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // DLAB phase: four visible cycles after edge 1..4, CFG after edge 5
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("dlab_dlr", {16'd0, DLR}, 32'd13);
      check("dlab_lcr_done", {23'd0, LCR, cfg_done}, {23'd0, 8'h80, 1'b0});
    end
    @(negedge PCLK);
    check("cfg_regs", {LCR, FCR, IER, MCR}, 32'h7B01FF10);
    check("cfg_done_early", {31'd0, cfg_done}, 32'd0);
    @(negedge PCLK);
    check("cfg_done", {31'd0, cfg_done}, 32'd1);

    // TX single byte
    tx_valid = 1'b1; tx_data = 8'hAF; LSR = 8'h20;
    apb_q.push_back('{1'b1, 8'hAF});
    #1 check("tx_ready_idle", {31'd0, tx_ready}, 32'd1);
    @(negedge PCLK);
    tx_valid = 1'b0;
    check("tx_setup", {28'd0, apb.PSEL, apb.PENABLE, apb.PWRITE, tx_ready}, 32'b1010);
    check("tx_pwdata", {24'd0, apb.PWDATA}, 32'hAF);
    @(negedge PCLK);
    check("tx_access", {29'd0, apb.PSEL, apb.PENABLE, tx_ready}, 32'b110);
    @(negedge PCLK);
    check("tx_gap1", {30'd0, apb.PSEL, tx_ready}, 32'd0);
    @(negedge PCLK);
    check("tx_gap2", {31'd0, tx_ready}, 32'd0);
    @(negedge PCLK);
    check("tx_ready_back", {31'd0, tx_ready}, 32'd1);

    // RX single byte
    LSR = 8'h01; rx_en = 1'b1; apb.PRDATA = 8'hD2;
    apb_q.push_back('{1'b0, 8'h00});
    rx_q.push_back(8'hD2);
    @(negedge PCLK);
    rx_en = 1'b0;
    check("rx_setup", {29'd0, apb.PSEL, apb.PENABLE, apb.PWRITE}, 32'b100);
    @(negedge PCLK);
    check("rx_access", {30'd0, apb.PSEL, apb.PENABLE}, 32'b11);
    @(negedge PCLK);
    check("rx_valid_pulse", {31'd0, rx_valid}, 32'd1);
    @(negedge PCLK);
    check("rx_valid_drop", {31'd0, rx_valid}, 32'd0);
    check("rx_data_hold", {24'd0, rx_data}, 32'hD2);
    @(negedge PCLK);

    // Tie: grants alternate TX, RX, TX, RX starting with TX (last grant was RX)
    tx_valid = 1'b1; tx_data = 8'hF0; rx_en = 1'b1; LSR = 8'h21; apb.PRDATA = 8'h3C;
    apb_q.push_back('{1'b1, 8'hF0});
    apb_q.push_back('{1'b0, 8'h00});
    apb_q.push_back('{1'b1, 8'hFF});
    apb_q.push_back('{1'b0, 8'h00});
    rx_q.push_back(8'h3C);
    rx_q.push_back(8'hC3);
    txn = 0; rxn = 0;
    for (int c = 0; c < 80 && !(txn == 2 && rxn == 2); c++) begin
      #1 acc = tx_valid && tx_ready;
      @(negedge PCLK);
      if (acc) begin
        txn++;
        if (txn == 1) tx_data = 8'hFF;
        else tx_valid = 1'b0;
      end
      if (rx_valid) begin
        rxn++;
        if (rxn == 1) apb.PRDATA = 8'hC3;
        else rx_en = 1'b0;
      end
    end
    check("tie_complete", {30'd0, txn == 2, rxn == 2}, 32'b11);

    // Gating: no flags, nothing moves
    LSR = 8'h00; tx_valid = 1'b1; tx_data = 8'h77; rx_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      check("gated_idle", {30'd0, apb.PSEL, tx_ready}, 32'd0);
    end
    LSR = 8'h20;
    apb_q.push_back('{1'b1, 8'h77});
    #1 check("ungate_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge PCLK);
    check("ungate_write", {30'd0, apb.PSEL, apb.PWRITE}, 32'b11);
    tx_valid = 1'b0; rx_en = 1'b0;
    repeat (4) @(negedge PCLK);

    // init_req during ACCESS: write finishes, then config reruns
    tx_valid = 1'b1; tx_data = 8'h96;
    apb_q.push_back('{1'b1, 8'h96});
    @(negedge PCLK);
    tx_valid = 1'b0;
    @(negedge PCLK);
    check("init_in_access", {30'd0, apb.PSEL, apb.PENABLE}, 32'b11);
    init_req = 1'b1;
    @(negedge PCLK);
    init_req = 1'b0;
    check("init_after_xfer", {29'd0, apb.PSEL, cfg_done, tx_ready}, 32'b010);
    waitn = 0;
    while (cfg_done && waitn < 20) begin
      @(negedge PCLK);
      waitn++;
    end
    check("init_fall_delay", waitn, 32'd3);
    check("init_dlab_regs", {LCR, DLR[7:0]}, {16'h800D});
    waitn = 0;
    while (!cfg_done && waitn < 30) begin
      @(negedge PCLK);
      waitn++;
    end
    check("init_rise_delay", waitn, 32'd6);
    check("init_cfg_lcr", {24'd0, LCR}, 32'h7B);

    // PRESET during SETUP drops the bus asynchronously
    tx_valid = 1'b1; tx_data = 8'h11;
    #1 acc = tx_ready;
    check("pre_reset_ready", {31'd0, acc}, 32'd1);
    @(negedge PCLK);
    check("reset_setup", {30'd0, apb.PSEL, apb.PENABLE}, 32'b10);
    #2 PRESET = 1'b1;
    #1 check("async_drop", {29'd0, apb.PSEL, apb.PENABLE, cfg_done}, 32'd0);
    check("async_lcr", {24'd0, LCR}, 32'h80);
    tx_valid = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (10) @(negedge PCLK);

    check("apb_q_drained", apb_q.size(), 32'd0);
    check("rx_q_drained", rx_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
